// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: merges load-use and memory-wait
// stalls with EX redirects into per-stage hold/flush controls, plus timeout and perf counters.
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id_i,
    input  logic             stallreq_mem_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic             clr_cnt_i,
    output logic [4:0]       stall_o,
    output logic             flush_ifid_o,
    output logic             flush_idex_o,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT);

    state_e             state_q, state_d;
    logic               pending_q, pending_d;
    logic [31:0]        target_q, target_d;
    logic [15:0]        wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic [15:0]        wait_inc;
    logic               run_decode;
    logic [4:0]         stall;
    logic               flush_ifid;
    logic               flush_idex;
    logic               redirect;
    logic [31:0]        redirect_pc;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        target_d    = target_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        run_decode  = 1'b0;
        stall       = '0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        wait_inc    = wait_cnt_q + 16'd1;

        case (state_q)
            RUN: begin
                if (stallreq_mem_i) begin
                    stall      = 5'b01111;
                    wait_cnt_d = 16'd1;
                    if (branch_taken_i) begin
                        pending_d = 1'b1;
                        target_d  = branch_target_i;
                    end
                    if (TIMEOUT_LIM == 16'd1) begin
                        state_d   = ERROR;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end else begin
                    run_decode = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (stallreq_mem_i) begin
                    stall      = 5'b01111;
                    wait_cnt_d = wait_inc;
                    // EX is held during the wait, so a repeated pulse is the same branch
                    if (branch_taken_i && !pending_q) begin
                        pending_d = 1'b1;
                        target_d  = branch_target_i;
                    end
                    if (wait_inc == TIMEOUT_LIM) begin
                        state_d   = ERROR;
                        timeout_d = 1'b1;
                    end
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    if (pending_q) begin
                        flush_ifid  = 1'b1;
                        flush_idex  = 1'b1;
                        redirect    = 1'b1;
                        redirect_pc = target_q;
                        pending_d   = 1'b0;
                    end else begin
                        run_decode = 1'b1;
                    end
                end
            end
            ERROR: begin
                stall = 5'b11111;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Shared RUN-style decode; the memory case has already been excluded above
        if (run_decode) begin
            if (branch_taken_i) begin
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                redirect    = 1'b1;
                redirect_pc = branch_target_i;
            end else if (stallreq_id_i) begin
                stall      = 5'b00011;
                flush_idex = 1'b1;
            end
        end
    end

    always_comb begin
        stall_o       = rst ? stall       : '0;
        flush_ifid_o  = rst ? flush_ifid  : 1'b0;
        flush_idex_o  = rst ? flush_idex  : 1'b0;
        redirect_o    = rst ? redirect    : 1'b0;
        redirect_pc_o = rst ? redirect_pc : '0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if ((stall_o != '0) && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (redirect_o && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            pending_q   <= 1'b0;
            target_q    <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            target_q    <= target_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_timeout_o  = timeout_q;
    assign stall_cycles_o = stall_cnt_q;
    assign flush_count_o  = flush_cnt_q;

endmodule
